// File: rtl/wbcmd_multi.sv
// wbcmd_multi: sequenced command engine. It accepts byte-burst requests,
// runs them as byte-wide Wishbone cycles and returns a header plus the
// data bytes as a pulled response stream.
module wbcmd_multi #(
    parameter int ADDR_W  = 16,
    parameter int NBYTES  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_stb_i,
    input  logic [5:0]            req_seq_i,
    input  logic                  req_we_i,
    input  logic [7:0]            req_len_i,
    input  logic [ADDR_W-1:0]     req_adr_i,
    input  logic [8*NBYTES-1:0]   req_dat_i,
    output logic                  req_ready_o,
    output logic                  wb_stb_o,
    output logic                  wb_cyc_o,
    output logic                  wb_we_o,
    output logic [ADDR_W-1:0]     wb_adr_o,
    output logic [7:0]            wb_dat_o,
    input  logic [7:0]            wb_dat_i,
    input  logic                  wb_ack_i,
    output logic [7:0]            resp_data,
    output logic [9:0]            resp_count,
    output logic                  resp_avail,
    input  logic                  resp_pull
);

    localparam int          IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [7:0]  NB8   = 8'(NBYTES);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t            state, state_nx;
    logic [5:0]        recv_seq;
    logic              to_flag;
    logic              bad;
    logic              we;
    logic [7:0]        len;
    logic [7:0]        k;
    logic [ADDR_W-1:0] adr_base;
    logic [7:0]        wbyte [NBYTES];
    logic [7:0]        rdat  [NBYTES];
    logic [31:0]       cnt;
    logic [9:0]        rlen;
    logic [9:0]        ridx;

    logic              take, seq_ok, ack, last, expire, pull_last;
    logic [7:0]        len_eff;

    // Request decode and transfer-completion conditions.
    always_comb begin
        take      = (state == IDLE) && req_stb_i;
        seq_ok    = (req_seq_i == recv_seq);
        len_eff   = (req_len_i > NB8) ? NB8 : req_len_i;
        ack       = (state == XFER) && wb_ack_i;
        last      = (k == len - 8'd1);
        expire    = (state == XFER) && !wb_ack_i && (TIMEOUT > 0) && (cnt == TO_LAST);
        pull_last = (state == RESP) && resp_pull && (ridx == rlen - 10'd1);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state and all outputs.
    always_comb begin
        state_nx    = state;
        req_ready_o = 1'b0;
        wb_stb_o    = 1'b0;
        wb_cyc_o    = 1'b0;
        wb_we_o     = 1'b0;
        wb_adr_o    = '0;
        wb_dat_o    = '0;
        resp_avail  = 1'b0;
        resp_count  = '0;
        resp_data   = '0;
        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (take) state_nx = (seq_ok && len_eff != 8'd0) ? XFER : RESP;
            end
            XFER: begin
                wb_stb_o = 1'b1;
                wb_cyc_o = 1'b1;
                wb_we_o  = we;
                wb_adr_o = adr_base + ADDR_W'(k);
                wb_dat_o = wbyte[IDX_W'(k)];
                // An ack in the final timeout cycle is checked first and wins.
                if ((ack && last) || expire) state_nx = RESP;
            end
            RESP: begin
                resp_avail = 1'b1;
                resp_count = rlen - ridx;
                resp_data  = (ridx == 10'd0) ? {bad, to_flag, recv_seq}
                                             : rdat[IDX_W'(ridx - 10'd1)];
                if (pull_last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Request capture, byte transfer bookkeeping and response stepping.
    always_ff @(posedge clk) begin
        if (rst) begin
            recv_seq <= '0;
            to_flag  <= 1'b0;
            bad      <= 1'b0;
            we       <= 1'b0;
            len      <= '0;
            k        <= '0;
            adr_base <= '0;
            cnt      <= '0;
            rlen     <= '0;
            ridx     <= '0;
            for (int unsigned i = 0; i < NBYTES; i++) begin
                wbyte[i] <= '0;
                rdat[i]  <= '0;
            end
        end else begin
            case (state)
                IDLE: if (take) begin
                    k       <= '0;
                    cnt     <= '0;
                    ridx    <= '0;
                    to_flag <= 1'b0;
                    // Clearing the data bytes up front makes untransferred
                    // and rejected-response bytes read back as zero.
                    for (int unsigned i = 0; i < NBYTES; i++) rdat[i] <= '0;
                    if (seq_ok) begin
                        recv_seq <= recv_seq + 6'd1;
                        bad      <= 1'b0;
                        len      <= len_eff;
                        adr_base <= req_adr_i;
                        we       <= req_we_i;
                        rlen     <= 10'(len_eff) + 10'd1;
                        for (int unsigned i = 0; i < NBYTES; i++)
                            wbyte[i] <= req_dat_i[8*i +: 8];
                    end else begin
                        bad  <= 1'b1;
                        rlen <= 10'd2;
                    end
                end
                XFER: begin
                    if (ack) begin
                        rdat[IDX_W'(k)] <= we ? 8'h00 : wb_dat_i;
                        cnt <= '0;
                        if (!last) k <= k + 8'd1;
                    end else if (expire) begin
                        to_flag <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                RESP: if (resp_pull) ridx <= ridx + 10'd1;
                default: ;
            endcase
        end
    end

endmodule
